// File: rtl/pipe_control_unit.sv
// pipe_control_unit: MIPS ID decode plus registered EX/MEM/WB control bundles.
// Also handles load-use and multiply-busy stalls and the branch/jump flush bubble.
module pipe_control_unit #(
  parameter int ALUOP_W     = 4,
  parameter int REG_W       = 5,
  parameter int MULT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [5:0]         id_op,
  input  logic [5:0]         id_funct,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               flush,
  output logic               id_jr,
  output logic               id_jal,
  output logic               id_jump,
  output logic               id_beq,
  output logic               id_bne,
  output logic               hazard_stall,
  output logic               mult_busy,
  output logic               illegal_op,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_mem_to_reg,
  output logic               wb_reg_write,
  output logic [REG_W-1:0]   ex_dest,
  output logic [REG_W-1:0]   mem_dest,
  output logic [REG_W-1:0]   wb_dest
);
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               illegal;
    logic [REG_W-1:0]   dest;
  } ctrl_t;
  ctrl_t dec, ex_d, ex_q;
  logic [REG_W+3:0] mem_d, mem_q;
  logic [REG_W+1:0] wb_d, wb_q;
  logic [3:0] cnt_d, cnt_q;
  logic jr, jal, jump, beq, bne, use_rs, use_rt, is_mult, is_mfx;
  logic funct_ok, load_use, raw_stall, load, gate;
  assign funct_ok = id_funct inside {6'h08, 6'h10, 6'h12, 6'h18} || (id_funct >= 6'h20 && id_funct <= 6'h2B);
  always_comb begin
    dec = '0;
    {jr, jal, jump, beq, bne, is_mult, is_mfx, use_rt} = '0;
    use_rs = 1'b1;
    case (id_op)
      6'h00: if (funct_ok) begin
        dec.reg_dst = 1'b1;
        dec.alu_op = ALUOP_W'(7);
        dec.reg_write = id_funct != 6'h18;
        use_rt = 1'b1;
        jr = id_funct == 6'h08;
        jump = id_funct == 6'h08;
        is_mult = id_funct == 6'h18;
        is_mfx = id_funct == 6'h10 || id_funct == 6'h12;
      end else begin
        dec.illegal = 1'b1;
        use_rs = 1'b0;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        dec.alu_src = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op = ALUOP_W'(id_op == 6'h08 ? 4 : id_op == 6'h0C ? 5 : id_op == 6'h0D ? 6 : 3);
        use_rs = id_op != 6'h0F;
      end
      6'h04, 6'h05: begin
        dec.alu_op = ALUOP_W'(id_op[0] ? 9 : 8);
        beq = !id_op[0];
        bne = id_op[0];
        use_rt = 1'b1;
      end
      6'h23: begin
        dec.alu_op = ALUOP_W'(10);
        {dec.alu_src, dec.mem_to_reg, dec.reg_write, dec.mem_read} = 4'hF;
      end
      6'h2B: begin
        dec.alu_op = ALUOP_W'(11);
        {dec.alu_src, dec.mem_write} = 2'b11;
        use_rt = 1'b1;
      end
      6'h02, 6'h03: begin
        dec.alu_op = ALUOP_W'(id_op[0] ? 2 : 1);
        jump = 1'b1;
        jal = id_op[0];
        dec.reg_write = id_op[0];
        use_rs = 1'b0;
      end
      default: begin
        dec.illegal = 1'b1;
        use_rs = 1'b0;
      end
    endcase
    dec.dest = !dec.reg_write ? '0 : jal ? REG_W'(31) : dec.reg_dst ? id_rd : id_rt;
  end
  always_comb begin
    load_use = ex_q.mem_read && ex_q.dest != '0 && ((use_rs && id_rs == ex_q.dest) || (use_rt && id_rt == ex_q.dest));
    raw_stall = load_use || (mult_busy && (is_mult || is_mfx));
    hazard_stall = id_valid && raw_stall && !flush;
    load = id_valid && !flush && !hazard_stall;
    gate = id_valid && !hazard_stall;
    ex_d = load ? dec : '0;
    // counter keeps running through stalls and flushes; only an accepted MULT reloads it
    cnt_d = (load && is_mult) ? 4'(MULT_CYCLES) : mult_busy ? cnt_q - 4'd1 : 4'd0;
    mem_d = {ex_q.mem_read, ex_q.mem_write, ex_q.mem_to_reg, ex_q.reg_write, ex_q.dest};
    wb_d = mem_q[REG_W+1:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ex_q <= '0;
      mem_q <= '0;
      wb_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      cnt_q <= cnt_d;
    end
  assign mult_busy = cnt_q != 4'd0;
  assign {id_jr, id_jal, id_jump, id_beq, id_bne} = {5{gate}} & {jr, jal, jump, beq, bne};
  assign {ex_reg_dst, ex_alu_src, ex_alu_op, ex_dest, illegal_op} = {ex_q.reg_dst, ex_q.alu_src, ex_q.alu_op, ex_q.dest, ex_q.illegal};
  assign {mem_read, mem_write, mem_dest} = {mem_q[REG_W+3:REG_W+2], mem_q[REG_W-1:0]};
  assign {wb_mem_to_reg, wb_reg_write, wb_dest} = wb_q;
endmodule
